apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/shared_pkg.sv | 13 +
 rtl/apb_req_arbiter_if.sv | 54 +++++
 rtl/apb_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shared_pkg
//  Description : Bus widths shared by the APB request arbiter and its users.
//  Revision    : 1.0 - initial release
// ============================================================================
package shared_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

endpackage : shared_pkg
`default_nettype wire

// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter_if
//  Description : Requester, response and APB-side signals of the arbiter.
//                slave  = arbiter view (takes requests, watches the bus).
//                master = environment view (raises requests, drives the bus).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int NUM_REQ    = 4
);

  // requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_slverr;
  logic                          rsp_timeout;

  // APB master request port
  logic                          start_transfer;
  logic [ADDR_WIDTH-1:0]         addr;
  logic                          wr;
  logic [DATA_WIDTH-1:0]         wdata;

  // monitored APB bus
  logic                          PSEL;
  logic                          PENABLE;
  logic                          PREADY;
  logic                          PSLVERR;
  logic [DATA_WIDTH-1:0]         PRDATA;

  modport slave (
    input  req, req_addr, req_wr, req_wdata,
    input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    output gnt, done, rsp_rdata, rsp_slverr, rsp_timeout,
    output start_transfer, addr, wr, wdata
  );

  modport master (
    output req, req_addr, req_wr, req_wdata,
    output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    input  gnt, done, rsp_rdata, rsp_slverr, rsp_timeout,
    input  start_transfer, addr, wr, wdata
  );

endinterface : apb_req_arbiter_if
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Round-robin arbiter that funnels NUM_REQ requesters onto one
//                APB master port, with a WAIT-state watchdog and a held
//                response (read data, error, timeout) per completed transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int ADDR_WIDTH     = shared_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = shared_pkg::DATA_WIDTH,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_req_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0]   C_IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_win;
  logic [CNT_W-1:0]      r_wd_cnt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_start;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_slverr;
  logic                  r_timeout;

  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_complete;
  logic [IDX_W-1:0]      w_ptr_next;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      automatic int idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && bus.req[IDX_W'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  // Pick the winner's address, direction and write-data slices.
  always_comb begin
    w_addr  = '0;
    w_wr    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_win) begin
        w_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr    = bus.req_wr[i];
        w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_complete = bus.PSEL & bus.PENABLE & bus.PREADY;
  assign w_ptr_next = (r_win == C_IDX_LAST) ? '0 : r_win + 1'b1;

  // Arbitration / transfer FSM; every output is a register of this block.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_win     <= '0;
      r_wd_cnt  <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_start   <= 1'b0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_ISSUE;
            r_win   <= w_win;
            r_gnt   <= C_ONE << w_win;
            r_addr  <= w_addr;
            r_wr    <= w_wr;
            r_wdata <= w_wdata;
            r_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_start  <= 1'b0;
          r_wd_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // A real completion takes priority over a watchdog expiry in the same cycle.
          if (w_complete) begin
            if (!r_wr) r_rdata <= bus.PRDATA;
            r_slverr  <= bus.PSLVERR;
            r_timeout <= 1'b0;
            r_done    <= r_gnt;
            r_state   <= S_RESP;
          end else if (r_wd_cnt == C_CNT_LAST) begin
            r_slverr  <= 1'b1;
            r_timeout <= 1'b1;
            r_done    <= r_gnt;
            r_state   <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_done   <= '0;
          r_gnt    <= '0;
          r_rr_ptr <= w_ptr_next;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt            = r_gnt;
  assign bus.done           = r_done;
  assign bus.start_transfer = r_start;
  assign bus.addr           = r_addr;
  assign bus.wr             = r_wr;
  assign bus.wdata          = r_wdata;
  assign bus.rsp_rdata      = r_rdata;
  assign bus.rsp_slverr     = r_slverr;
  assign bus.rsp_timeout    = r_timeout;

endmodule : apb_req_arbiter
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Self-checking bench for apb_req_arbiter: directed vector
//                table, fairness and reset-in-WAIT sequences, then random
//                transfers checked against a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int T  = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  apb_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int            m_ptr;
  logic [DW-1:0] m_rdata;

  typedef struct {
    logic [N-1:0]  req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ws;      // access cycles with PREADY low; -1 = never ready
    logic          perr;
    logic [DW-1:0] prdata;
    bit            drop;    // release req right after the grant
    logic [N-1:0]  exp_gnt;
    logic          exp_err;
    logic          exp_to;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
  endtask

  // Round-robin rule: first requester at or above ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    bus.gnt, 0);
    check({tag, "_done"},   bus.done, 0);
    check({tag, "_start"},  bus.start_transfer, 0);
    check({tag, "_addr"},   bus.addr, 0);
    check({tag, "_wr"},     bus.wr, 0);
    check({tag, "_wdata"},  bus.wdata, 0);
    check({tag, "_rdata"},  bus.rsp_rdata, 0);
    check({tag, "_slverr"}, bus.rsp_slverr, 0);
    check({tag, "_tmo"},    bus.rsp_timeout, 0);
  endtask

  // One full transfer from request to the idle cycle after done.
  task automatic run_txn(input logic [N-1:0] mask, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ws, input logic perr,
                         input logic [DW-1:0] prd, input bit keep_req, input bit drop_early,
                         input logic [N-1:0] exp_gnt, input logic exp_err, input logic exp_to,
                         input logic [DW-1:0] exp_rd);
    int  w;
    int  edges;
    int  k;
    int  n_wait;
    bit  seen;
    w = 0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) w = i;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = (i == w) ? a : ~a;
      bus.req_wr[i]             = (i == w) ? wr : ~wr;
      bus.req_wdata[i*DW +: DW] = (i == w) ? d : ~d;
    end
    bus.req = mask;

    edges = 0;
    seen  = 0;
    while (!seen && edges < 8) begin
      tick();
      edges++;
      if (bus.gnt != '0) seen = 1;
    end
    check("grant_arrives", seen, 1);
    if (!seen) begin
      bus.req = '0;
      bus_idle();
      return;
    end
    check("req_to_gnt_edges", edges, 1);
    check("gnt", bus.gnt, exp_gnt);
    check("start_issue", bus.start_transfer, 1);
    check("addr", bus.addr, a);
    check("wr", bus.wr, wr);
    check("wdata", bus.wdata, d);

    // Requesters may change their slices once granted.
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = $urandom;
      bus.req_wdata[i*DW +: DW] = $urandom;
    end
    bus.req_wr = ~bus.req_wr;
    if (drop_early) bus.req = '0;

    tick();
    check("start_one_cycle", bus.start_transfer, 0);

    n_wait = (ws >= 0 && ws + 2 <= T) ? ws + 2 : T;
    edges  = 1;
    k      = 1;
    seen   = 0;
    while (!seen && edges < T + 6) begin
      bus.PSEL    = 1'b1;
      bus.PENABLE = (k >= 2);
      bus.PREADY  = (k >= 2 && ws >= 0 && (k - 1) > ws);
      bus.PSLVERR = (k >= 2) ? perr : 1'b0;
      bus.PRDATA  = bus.PREADY ? prd : DW'($urandom);
      tick();
      edges++;
      k++;
      if (bus.done != '0) seen = 1;
    end
    check("done_seen", seen, 1);
    check("done_latency", edges, n_wait + 1);
    check("done", bus.done, exp_gnt);
    check("gnt_in_done", bus.gnt, exp_gnt);
    check("rsp_slverr", bus.rsp_slverr, exp_err);
    check("rsp_timeout", bus.rsp_timeout, exp_to);
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("addr_held", bus.addr, a);
    check("wr_held", bus.wr, wr);
    check("wdata_held", bus.wdata, d);

    bus_idle();
    if (!keep_req) bus.req = '0;
    tick();
    check("gnt_cleared", bus.gnt, 0);
    check("done_one_cycle", bus.done, 0);
    check("rsp_held", bus.rsp_rdata, exp_rd);
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] one;
    one = 1;

    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_wr    = '0;
    bus.req_wdata = '0;
    bus_idle();

    // reset state
    PRESETn = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    PRESETn = 1'b1;

    // directed vectors from reset (rr pointer at 0)
    tbl[0] = '{4'b0010, 1'b1, 32'h10,  32'hA5,   0, 1'b0, 32'h0,        1'b0, 4'b0010, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{4'b0001, 1'b0, 32'h200, 32'h0,    3, 1'b0, 32'hDEADBEEF, 1'b0, 4'b0001, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{4'b1000, 1'b0, 32'h300, 32'h0,   -1, 1'b0, 32'h11111111, 1'b1, 4'b1000, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{4'b0100, 1'b1, 32'h400, 32'h5A5A, 14, 1'b1, 32'h22222222, 1'b0, 4'b0100, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{4'b0110, 1'b0, 32'h500, 32'h0,   13, 1'b0, 32'h12345678, 1'b0, 4'b0010, 1'b0, 1'b0, 32'h12345678};
    tbl[5] = '{4'b0011, 1'b1, 32'h600, 32'h77,   1, 1'b1, 32'h33,       1'b0, 4'b0001, 1'b1, 1'b0, 32'h12345678};
    tbl[6] = '{4'b0010, 1'b0, 32'h700, 32'h0,   15, 1'b0, 32'h44,       1'b0, 4'b0010, 1'b1, 1'b1, 32'h12345678};
    for (int v = 0; v < 7; v++) begin
      run_txn(tbl[v].req, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].ws, tbl[v].perr,
              tbl[v].prdata, 1'b0, tbl[v].drop, tbl[v].exp_gnt, tbl[v].exp_err,
              tbl[v].exp_to, tbl[v].exp_rd);
    end

    // fairness with all four requesters held
    do_reset();
    run_txn(4'b1111, 1'b1, 32'h1000, 32'h1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0);
    run_txn(4'b1111, 1'b1, 32'h1004, 32'h2, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 32'h0);
    run_txn(4'b1111, 1'b1, 32'h1008, 32'h3, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 32'h0);
    run_txn(4'b1111, 1'b1, 32'h100C, 32'h4, 0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0);
    run_txn(4'b1111, 1'b1, 32'h1010, 32'h5, 0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0);

    // reset in WAIT: make response registers non-zero first, pointer ends at 1
    run_txn(4'b0001, 1'b0, 32'h2000, 32'h0, 0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0,
            4'b0001, 1'b1, 1'b0, 32'hCAFE0001);
    bus.req_addr  = {4{32'h3000}};
    bus.req_wdata = {4{32'h99}};
    bus.req_wr    = 4'b1111;
    bus.req       = 4'b1001;
    tick();
    check("rst_seq_gnt", bus.gnt, 4'b1000);
    tick();
    bus.PSEL = 1'b1;
    tick();
    bus.PENABLE = 1'b1;
    tick();
    PRESETn = 1'b0;
    tick();
    check_all_zero("rst_wait");
    PRESETn = 1'b1;
    bus_idle();
    run_txn(4'b1001, 1'b1, 32'h3100, 32'h42, 2, 1'b0, 32'h0, 1'b0, 1'b0,
            4'b0001, 1'b0, 1'b0, 32'h0);

    // random transfers against the reference model
    do_reset();
    m_ptr   = 0;
    m_rdata = '0;
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0]  mask;
      logic          wr;
      logic          perr;
      logic [DW-1:0] prd;
      int            ws;
      int            w;
      bit            completed;
      mask      = N'($urandom_range(1, (1 << N) - 1));
      wr        = 1'($urandom);
      ws        = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 16));
      perr      = ($urandom_range(0, 3) == 0);
      prd       = $urandom;
      w         = pick(mask, m_ptr);
      completed = (ws >= 0) && (ws + 2 <= T);
      if (completed && !wr) m_rdata = prd;
      run_txn(mask, wr, AW'($urandom), DW'($urandom), ws, perr, prd, 1'b0, 1'($urandom),
              one << w, completed ? perr : 1'b1, !completed, m_rdata);
      m_ptr = (w + 1) % N;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_apb_req_arbiter
`default_nettype wire
